// File: rtl/ieee_conv_pkg.sv
// Shared types and constants for the IEEE-754 to 5.5 fixed-point conversion arbiter.
package ieee_conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      RESP
   } state_e;

   localparam int EXP_BIAS   = 127;
   localparam int MAX_POW    = 4;
   localparam int FIX_INT_W  = 5;
   localparam int FIX_FRAC_W = 5;

endpackage

// File: rtl/ieee_conv_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the shared converter (slave).
interface ieee_conv_arbiter_if
   import ieee_conv_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [32*NREQ-1:0]    req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [FIX_INT_W-1:0]  resp_digit;
   logic [FIX_FRAC_W-1:0] resp_float;
   logic                  resp_err;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_digit, resp_float, resp_err
   );

   modport slave (
      input  req_valid, req_data, resp_ready,
      output req_ready, resp_valid, resp_id, resp_digit, resp_float, resp_err
   );

endinterface

// File: rtl/ieee_fix_core.sv
// Combinational IEEE-754 single to 5.5 fixed-point converter with range-error flag.
// Define IEEE_CONV_SAT_EN to return all-ones (instead of zero) for too-large operands.
module ieee_fix_core
   import ieee_conv_pkg::*;
(
   input  logic [31:0]           op,
   output logic [FIX_INT_W-1:0]  digit,
   output logic [FIX_FRAC_W-1:0] frac,
   output logic                  err
);

   logic       sign;
   logic [7:0] expo;
   logic [22:0] mant;
   logic       under;
   logic       over;
   logic [2:0] pow;
   logic [2:0] int_shamt;
   logic [4:0] int_full;

   always_comb begin
      sign  = op[31];
      expo  = op[30:23];
      mant  = op[22:0];
      under = sign || (expo < 8'(EXP_BIAS));
      over  = expo > 8'(EXP_BIAS + MAX_POW);
      err   = under || over;

      // pow is only meaningful in range; out-of-range results are overridden below
      pow       = 3'(expo - 8'(EXP_BIAS));
      int_shamt = 3'(MAX_POW) - pow;
      int_full  = {1'b1, mant[22:19]};
      digit     = int_full >> int_shamt;
      frac      = 5'((mant << pow) >> 18);

      if (err) begin
`ifdef IEEE_CONV_SAT_EN
         digit = under ? '0 : '1;
         frac  = under ? '0 : '1;
`else
         digit = '0;
         frac  = '0;
`endif
      end
   end

endmodule

// File: rtl/ieee_conv_arbiter.sv
// Round-robin arbiter and IDLE/CONV/RESP sequencer sharing one ieee_fix_core among NREQ requesters.
module ieee_conv_arbiter
   import ieee_conv_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
)(
   input  logic               clk,
   input  logic               rst,
   ieee_conv_arbiter_if.slave bus
);

   state_e                state_q, state_d;
   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [31:0]           op_q, op_d;
   logic [IDW-1:0]        resp_id_q, resp_id_d;
   logic [FIX_INT_W-1:0]  resp_digit_q, resp_digit_d;
   logic [FIX_FRAC_W-1:0] resp_float_q, resp_float_d;
   logic                  resp_err_q, resp_err_d;

   logic                  grant_found;
   logic [IDW-1:0]        grant_idx;
   logic [IDW-1:0]        grant_next;
   logic [IDW-1:0]        cand;
   logic [31:0]           grant_word;
   logic [NREQ-1:0]       req_ready_c;
   int                    scan;

   logic [FIX_INT_W-1:0]  core_digit;
   logic [FIX_FRAC_W-1:0] core_frac;
   logic                  core_err;

   ieee_fix_core u_core (
      .op    (op_q),
      .digit (core_digit),
      .frac  (core_frac),
      .err   (core_err)
   );

   // Scan downward so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_word  = '0;
      scan        = 0;
      cand        = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan = int'(rr_ptr_q) + k;
         if (scan >= NREQ) scan = scan - NREQ;
         cand = IDW'(scan);
         if (bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) grant_word = bus.req_data[32*i +: 32];
      end
      grant_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_comb begin
      req_ready_c = '0;
      if (!rst && state_q == IDLE && grant_found) req_ready_c[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      op_d         = op_q;
      resp_id_d    = resp_id_q;
      resp_digit_d = resp_digit_q;
      resp_float_d = resp_float_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               op_d     = grant_word;
               id_d     = grant_idx;
               rr_ptr_d = grant_next;
               state_d  = CONV;
            end
         end
         CONV: begin
            resp_id_d    = id_q;
            resp_digit_d = core_digit;
            resp_float_d = core_frac;
            resp_err_d   = core_err;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         op_q         <= '0;
         resp_id_q    <= '0;
         resp_digit_q <= '0;
         resp_float_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         op_q         <= op_d;
         resp_id_q    <= resp_id_d;
         resp_digit_q <= resp_digit_d;
         resp_float_q <= resp_float_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_digit = resp_digit_q;
   assign bus.resp_float = resp_float_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_ieee_conv_arbiter.sv
// Self-checking bench for ieee_conv_arbiter: vector table, round-robin, backpressure and mid-flight reset.
module tb_ieee_conv_arbiter;
   import ieee_conv_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

`ifdef IEEE_CONV_SAT_EN
   localparam logic [4:0] SAT = 5'h1F;
`else
   localparam logic [4:0] SAT = 5'h00;
`endif

   typedef struct packed {
      logic [1:0] id;
      logic [4:0] digit;
      logic [4:0] frac;
      logic       err;
   } resp_t;

   typedef struct {
      logic [1:0]  req_id;
      logic [31:0] data;
      logic [4:0]  exp_digit;
      logic [4:0]  exp_frac;
      logic        exp_err;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] valid_r = '0;
   logic [31:0]     words [NREQ];
   logic            resp_ready_r = 1'b1;

   resp_t exp_q [$];
   int    pass_count  = 0;
   int    check_count = 0;

   always #5 clk = ~clk;

   ieee_conv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   ieee_conv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   assign bus.req_valid  = valid_r;
   assign bus.resp_ready = resp_ready_r;
   always_comb begin
      for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = words[i];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Scoreboard: every completed response must match the oldest expected entry.
   always @(negedge clk) begin
      resp_t e;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         checkOutput("resp_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("resp_id",    32'(bus.resp_id),    32'(e.id));
            checkOutput("resp_digit", 32'(bus.resp_digit), 32'(e.digit));
            checkOutput("resp_float", 32'(bus.resp_float), 32'(e.frac));
            checkOutput("resp_err",   32'(bus.resp_err),   32'(e.err));
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] id, input logic [31:0] data, input resp_t expv, input string name);
      int n;
      logic hs;
      words[id]  = data;
      valid_r[id] = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 20) begin
         @(negedge clk);
         n++;
         hs = bus.req_ready[id];
      end
      checkOutput({name, "_accept"}, 32'(hs), 1);
      if (!hs) begin
         valid_r[id] = 1'b0;
         return;
      end
      checkOutput({name, "_onehot"}, 32'(bus.req_ready), 32'(4'b0001 << id));
      exp_q.push_back(expv);
      @(posedge clk); #1;
      valid_r[id] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.resp_valid && n < 20);
      checkOutput({name, "_latency"}, 32'(n), 2);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_drain"}, 32'(exp_q.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_req_ready"},  32'(bus.req_ready),  0);
      checkOutput({name, "_resp_valid"}, 32'(bus.resp_valid), 0);
      checkOutput({name, "_resp_id"},    32'(bus.resp_id),    0);
      checkOutput({name, "_resp_digit"}, 32'(bus.resp_digit), 0);
      checkOutput({name, "_resp_float"}, 32'(bus.resp_float), 0);
      checkOutput({name, "_resp_err"},   32'(bus.resp_err),   0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs [12];
      int   grants, cyc, last;
      logic [1:0] rr_order [5];
      logic hs;
      int   n;

      vecs[0]  = '{2'd1, 32'h40A00000, 5'b00101, 5'b00000, 1'b0};
      vecs[1]  = '{2'd0, 32'h3FC00000, 5'b00001, 5'b10000, 1'b0};
      vecs[2]  = '{2'd2, 32'h41980000, 5'b10011, 5'b00000, 1'b0};
      vecs[3]  = '{2'd3, 32'h42000000, SAT,      SAT,      1'b1};
      vecs[4]  = '{2'd0, 32'hBF800000, 5'b00000, 5'b00000, 1'b1};
      vecs[5]  = '{2'd1, 32'h40490FDB, 5'b00011, 5'b00100, 1'b0};
      vecs[6]  = '{2'd2, 32'h3F800000, 5'b00001, 5'b00000, 1'b0};
      vecs[7]  = '{2'd3, 32'h41FFFFFF, 5'b11111, 5'b11111, 1'b0};
      vecs[8]  = '{2'd0, 32'h00000000, 5'b00000, 5'b00000, 1'b1};
      vecs[9]  = '{2'd1, 32'h7F800000, SAT,      SAT,      1'b1};
      vecs[10] = '{2'd2, 32'h3F000000, 5'b00000, 5'b00000, 1'b1};
      vecs[11] = '{2'd3, 32'h7FC00000, SAT,      SAT,      1'b1};

      for (int i = 0; i < NREQ; i++) words[i] = '0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven single conversions
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].req_id, vecs[i].data,
                       '{vecs[i].req_id, vecs[i].exp_digit, vecs[i].exp_frac, vecs[i].exp_err},
                       $sformatf("vec%0d", i));
      end
      drain("vectors");

      // Round-robin: all requesters valid from reset
      rst = 1'b1;
      words[0] = 32'h3F800000;
      words[1] = 32'h3FC00000;
      words[2] = 32'h40A00000;
      words[3] = 32'h41980000;
      valid_r  = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rr_reset_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_q.push_back('{2'd0, 5'b00001, 5'b00000, 1'b0});
      exp_q.push_back('{2'd1, 5'b00001, 5'b10000, 1'b0});
      exp_q.push_back('{2'd2, 5'b00101, 5'b00000, 1'b0});
      exp_q.push_back('{2'd3, 5'b10011, 5'b00000, 1'b0});
      exp_q.push_back('{2'd0, 5'b00001, 5'b00000, 1'b0});
      grants = 0;
      cyc    = 0;
      last   = 0;
      while (grants < 5 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.req_ready != '0) begin
            checkOutput($sformatf("rr_grant%0d", grants), 32'(bus.req_ready), 32'(4'b0001 << rr_order[grants]));
            if (grants > 0) checkOutput($sformatf("rr_interval%0d", grants), 32'(cyc - last), 3);
            last = cyc;
            grants++;
         end
      end
      checkOutput("rr_grant_count", 32'(grants), 5);
      @(posedge clk); #1;
      valid_r = '0;
      drain("rr");

      // Backpressure: hold resp_ready low for 10 cycles in RESP
      resp_ready_r = 1'b0;
      words[2]   = 32'h41980000;
      valid_r[2] = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 20) begin
         @(negedge clk);
         n++;
         hs = bus.req_ready[2];
      end
      checkOutput("bp_accept", 32'(hs), 1);
      exp_q.push_back('{2'd2, 5'b10011, 5'b00000, 1'b0});
      @(posedge clk); #1;
      valid_r[2] = 1'b0;
      words[0]   = 32'h3F800000;
      valid_r[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.resp_valid && n < 20);
      checkOutput("bp_latency", 32'(n), 2);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         checkOutput($sformatf("bp_valid%0d", c), 32'(bus.resp_valid), 1);
         checkOutput($sformatf("bp_digit%0d", c), 32'(bus.resp_digit), 32'(5'b10011));
         checkOutput($sformatf("bp_id%0d", c),    32'(bus.resp_id),    2);
         checkOutput($sformatf("bp_ready%0d", c), 32'(bus.req_ready),  0);
      end
      @(posedge clk); #1;
      resp_ready_r = 1'b1;
      @(negedge clk);
      checkOutput("bp_complete_valid", 32'(bus.resp_valid), 1);
      @(negedge clk);
      checkOutput("bp_after_valid", 32'(bus.resp_valid), 0);
      checkOutput("bp_after_ready", 32'(bus.req_ready),  32'(4'b0001));
      exp_q.push_back('{2'd0, 5'b00001, 5'b00000, 1'b0});
      @(posedge clk); #1;
      valid_r[0] = 1'b0;
      drain("bp");

      // Reset while in CONV drops the operand
      words[2]   = 32'h40A00000;
      valid_r[2] = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 20) begin
         @(negedge clk);
         n++;
         hs = bus.req_ready[2];
      end
      checkOutput("rst_accept", 32'(hs), 1);
      @(posedge clk); #1;
      valid_r[2] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("rst_conv");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput($sformatf("rst_no_resp%0d", c), 32'(bus.resp_valid), 0);
      end
      @(posedge clk); #1;
      words[0] = 32'h3FC00000;
      words[3] = 32'h41980000;
      valid_r  = 4'b1001;
      @(negedge clk);
      checkOutput("rst_ptr_grant", 32'(bus.req_ready), 32'(4'b0001));
      exp_q.push_back('{2'd0, 5'b00001, 5'b10000, 1'b0});
      @(posedge clk); #1;
      valid_r = '0;
      drain("rst");

      checkOutput("final_queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
